vga_pin_monitor: RTL and testbench
==================================

# vga_pin_monitor

Receive-side checker for the demo's TinyVGA output pinout, with audio on uio[7:6]. It samples the 16 output pins as a monitor or as a second tile, decodes active-low syncs, 2-bit RGB and the differential audio pair, and measures line and frame geometry. Per frame it also computes a CRC-16 over the pixel stream and an audio duty count, then latches one result record per frame. It is used in the FPGA/ASIC self-test path and as a scoreboard front end in simulation.

## Interface
Parameters:
- `CNT_BITS`, 11: width of the horizontal and vertical counters.
- `AUD_BITS`, 20: width of the per-frame audio high-sample counter.
- `CRC_POLY`, 16'h1021: CRC-16 polynomial. Init value is 16'hFFFF; no reflection, no final XOR.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  **asynchronous, active-high** reset.
- `sample_en`  in  1  pins are sampled only on cycles where this is high. It mirrors the producer's pixel `enable`.
- `uo_pins`  in  8  {!hsync, b0, g0, r0, !vsync, b1, g1, r1}.
- `uio_pins`  in  8  [7]=audio, [6]=!audio; [5:0] are ignored.
- `frame_done`  out  1  one-cycle pulse when a new record is latched.
- `locked`  out  1  high after the first vsync assertion has been seen.
- `h_total`  out  CNT_BITS  samples between the last two hsync assertions.
- `h_sync_len`  out  CNT_BITS  samples hsync was asserted on the last line.
- `v_total`  out  CNT_BITS  hsync assertions in the last frame.
- `v_sync_len`  out  CNT_BITS  hsync assertions while vsync was asserted.
- `pix_crc`  out  16  CRC over the 6-bit {r1,r0,g1,g0,b1,b0} of every sample in the last frame.
- `aud_high`  out  AUD_BITS  samples with audio=1 in the last frame.
- `err`  out  4  sticky flags. [0] audio pair not complementary; [1] counter saturated; [2] v_total changed between frames; [3] h_total changed between lines.

## Operation
- Input stage: when `sample_en`=1, `uo_pins`/`uio_pins` are registered into the sample register and `s_valid` is set. Otherwise `s_valid`=0 and the register holds. All further logic acts only on `s_valid` cycles.
- Decode: hsync = !uo[7], vsync = !uo[3]. An edge is an assertion 0→1 relative to the previous *valid* sample.
- State machine:
  - HUNT: counters are cleared. On a vsync assertion → RUN, set `locked`, and start the first frame. This first assertion does not latch a record or pulse `frame_done`.
  - RUN: accumulate. On each vsync assertion, latch all per-frame results, pulse `frame_done`, clear the accumulators and re-init the CRC. This edge sample is included as the first sample of the new frame.
- Horizontal:
  - `hcnt` increments per valid sample.
  - On an hsync assertion, latch `h_total`=hcnt, compare with the previous `h_total` (err[3], only when the previous value is non-zero), and reset hcnt to 1.
  - `hs_cnt` counts samples with hsync=1 and latches into `h_sync_len` on the hsync deassertion.
- Vertical:
  - `vcnt` counts hsync assertions.
  - `vs_lines` counts hsync assertions that occur while vsync=1.
  - Both latch at frame end. err[2] compares the new `v_total` with the previous record; it is skipped for the first record.
- CRC: bitwise MSB-first, 6 bits per valid sample (r1 first), using the combinational next-state of all 6 bits in one cycle.
- Audio: `aud_high` increments when uio[7]=1. err[0] is set when uio[7]==uio[6].
- Arithmetic: all counters saturate at all-ones and set err[1]; they never wrap.
- Simultaneous hsync and vsync assertion in the same sample: the hsync edge counts toward the new frame (vcnt restarts at 1).
- `err` bits clear only on reset.

## Timing
- Reset values:
  - outputs `frame_done`=0, `locked`=0, `h_total`=`h_sync_len`=`v_total`=`v_sync_len`=0, `pix_crc`=16'h0000, `aud_high`=0, `err`=0;
  - internal CRC state = FFFF; state = HUNT.
- Latency: sample on edge k (sample_en=1), results/`frame_done` at edge k+1 (visible from k+1). If the k sample is a vsync edge, `frame_done` is high exactly one cycle.
- `sample_en` gaps are transparent: a stall of any length changes no result.
- Reset asserted mid-frame clears everything asynchronously. After release the block is in HUNT and needs a fresh vsync assertion.

## Structure
- Shared package `vga_mon_pkg`: pin bit indices for TinyVGA (HS=7, VS=3, R1=0, G1=1, B1=2, R0=4, G0=5, B0=6, AUD=7, AUDN=6), the CRC init constant, the `err` bit indices, and the state enum {HUNT, RUN}.
- Sub-module `crc16_step6`: a combinational 6-bit CRC update (crc_in, data6 → crc_out), parameterised by poly.

## Test plan
- Frame of 10×6 samples, hsync asserted 2 samples per line, vsync asserted lines 0–1, all pixels black → second `frame_done` gives h_total=10, h_sync_len=2, v_total=6, v_sync_len=2, err=0.
- Same geometry, pixel data ramp 0..59 mod 64 → `pix_crc` equals the golden model value, identical on three consecutive frames.
- Audio pin toggling 1 of every 4 samples with uio[6]=!uio[7] → aud_high=15 for a 60-sample frame. Forcing uio[6]=uio[7] for one sample sets err[0] and it stays set.
- `sample_en` high only every 3rd cycle → records are identical to the continuous case; `frame_done` occurs one cycle after the vsync-edge sample.
- Line 3 shortened to 9 samples → err[3] set. Next frame with v_total=7 → err[2] set.
- Reset pulsed mid-frame → all outputs 0 and locked=0 immediately. First record after reset comes on the second subsequent vsync assertion.

Source files
------------

// File: rtl/vga_mon_pkg.sv
// Shared definitions for the TinyVGA receive-side pin monitor: pin positions,
// CRC seed, error flag positions and the lock state encoding.
package vga_mon_pkg;

    localparam int PIN_R1   = 0;
    localparam int PIN_G1   = 1;
    localparam int PIN_B1   = 2;
    localparam int PIN_VS   = 3;
    localparam int PIN_R0   = 4;
    localparam int PIN_G0   = 5;
    localparam int PIN_B0   = 6;
    localparam int PIN_HS   = 7;
    localparam int PIN_AUD  = 7;
    localparam int PIN_AUDN = 6;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam int ERR_AUD  = 0;
    localparam int ERR_SAT  = 1;
    localparam int ERR_VTOT = 2;
    localparam int ERR_HTOT = 3;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } mon_state_e;

endpackage

// File: rtl/crc16_step6.sv
// One-cycle CRC-16 update over six data bits, MSB (data6[5]) shifted in first.
module crc16_step6 #(
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic [15:0] crc_in,
    input  logic [5:0]  data6,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 5; i >= 0; i--) begin
            if (c[15] ^ data6[i]) begin
                c = {c[14:0], 1'b0} ^ POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/vga_pin_monitor.sv
// Samples the TinyVGA output pins, locks to vsync and publishes one record of
// line/frame geometry, pixel CRC and audio duty per frame, plus sticky errors.
module vga_pin_monitor
    import vga_mon_pkg::*;
#(
    parameter int          CNT_BITS = 11,
    parameter int          AUD_BITS = 20,
    parameter logic [15:0] CRC_POLY = 16'h1021
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [7:0]          uo_pins,
    input  logic [7:0]          uio_pins,
    output logic                frame_done,
    output logic                locked,
    output logic [CNT_BITS-1:0] h_total,
    output logic [CNT_BITS-1:0] h_sync_len,
    output logic [CNT_BITS-1:0] v_total,
    output logic [CNT_BITS-1:0] v_sync_len,
    output logic [15:0]         pix_crc,
    output logic [AUD_BITS-1:0] aud_high,
    output logic [3:0]          err
);

    function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [AUD_BITS-1:0] aud_inc(input logic [AUD_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    mon_state_e          state_q, state_d;
    logic                s_valid_q, s_valid_d;
    logic [7:0]          uo_q, uo_d;
    logic [1:0]          aud_s_q, aud_s_d;
    logic                hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [CNT_BITS-1:0] hcnt_q, hcnt_d, hs_cnt_q, hs_cnt_d;
    logic [CNT_BITS-1:0] vcnt_q, vcnt_d, vs_lines_q, vs_lines_d;
    logic [15:0]         crc_q, crc_d;
    logic [AUD_BITS-1:0] aud_q, aud_d;
    logic                rec_valid_q, rec_valid_d;
    logic                frame_done_q, frame_done_d;
    logic [CNT_BITS-1:0] h_total_q, h_total_d, h_sync_len_q, h_sync_len_d;
    logic [CNT_BITS-1:0] v_total_q, v_total_d, v_sync_len_q, v_sync_len_d;
    logic [15:0]         pix_crc_q, pix_crc_d;
    logic [AUD_BITS-1:0] aud_high_q, aud_high_d;
    logic [3:0]          err_q, err_d;

    logic                hs, vs, hs_rise, hs_fall, vs_rise, sat;
    logic [5:0]          pix6;
    logic [15:0]         crc_base, crc_next;
    logic [CNT_BITS-1:0] vcnt_b, vsl_b;
    logic [AUD_BITS-1:0] aud_b;
    logic                unused_uio;

    assign unused_uio = ^uio_pins[5:0];

    assign hs      = ~uo_q[PIN_HS];
    assign vs      = ~uo_q[PIN_VS];
    assign hs_rise = hs & ~hs_prev_q;
    assign hs_fall = ~hs & hs_prev_q;
    assign vs_rise = vs & ~vs_prev_q;
    assign pix6    = {uo_q[PIN_R1], uo_q[PIN_R0], uo_q[PIN_G1],
                      uo_q[PIN_G0], uo_q[PIN_B1], uo_q[PIN_B0]};

    // The vsync-edge sample is the first sample of the new frame.
    assign crc_base = vs_rise ? CRC_INIT : crc_q;

    crc16_step6 #(.POLY(CRC_POLY)) u_crc (
        .crc_in (crc_base),
        .data6  (pix6),
        .crc_out(crc_next)
    );

    always_comb begin
        s_valid_d    = sample_en;
        uo_d         = sample_en ? uo_pins : uo_q;
        aud_s_d      = sample_en ? {uio_pins[PIN_AUD], uio_pins[PIN_AUDN]} : aud_s_q;
        state_d      = state_q;
        hs_prev_d    = hs_prev_q;
        vs_prev_d    = vs_prev_q;
        hcnt_d       = hcnt_q;
        hs_cnt_d     = hs_cnt_q;
        vcnt_d       = vcnt_q;
        vs_lines_d   = vs_lines_q;
        crc_d        = crc_q;
        aud_d        = aud_q;
        rec_valid_d  = rec_valid_q;
        frame_done_d = 1'b0;
        h_total_d    = h_total_q;
        h_sync_len_d = h_sync_len_q;
        v_total_d    = v_total_q;
        v_sync_len_d = v_sync_len_q;
        pix_crc_d    = pix_crc_q;
        aud_high_d   = aud_high_q;
        err_d        = err_q;
        sat          = 1'b0;
        vcnt_b       = vs_rise ? '0 : vcnt_q;
        vsl_b        = vs_rise ? '0 : vs_lines_q;
        aud_b        = vs_rise ? '0 : aud_q;

        if (s_valid_q) begin
            hs_prev_d = hs;
            vs_prev_d = vs;
            if (aud_s_q[1] == aud_s_q[0]) err_d[ERR_AUD] = 1'b1;

            if (state_q == RUN || vs_rise) begin
                state_d = RUN;

                if (vs_rise && state_q == RUN) begin
                    frame_done_d = 1'b1;
                    rec_valid_d  = 1'b1;
                    v_total_d    = vcnt_q;
                    v_sync_len_d = vs_lines_q;
                    pix_crc_d    = crc_q;
                    aud_high_d   = aud_q;
                    if (rec_valid_q && vcnt_q != v_total_q) err_d[ERR_VTOT] = 1'b1;
                end

                // hcnt stays 0 until the first line start after lock, so a
                // partial line is never reported as a line length.
                if (hs_rise) begin
                    hcnt_d = {{(CNT_BITS-1){1'b0}}, 1'b1};
                    if (hcnt_q != '0) begin
                        h_total_d = hcnt_q;
                        if (h_total_q != '0 && hcnt_q != h_total_q) err_d[ERR_HTOT] = 1'b1;
                    end
                end else if (hcnt_q != '0) begin
                    hcnt_d = cnt_inc(hcnt_q);
                    sat    = sat | (&hcnt_q);
                end

                if (hs_fall) begin
                    h_sync_len_d = hs_cnt_q;
                    hs_cnt_d     = '0;
                end else if (hs) begin
                    hs_cnt_d = cnt_inc(hs_cnt_q);
                    sat      = sat | (&hs_cnt_q);
                end

                vcnt_d     = vcnt_b;
                vs_lines_d = vsl_b;
                if (hs_rise) begin
                    vcnt_d = cnt_inc(vcnt_b);
                    sat    = sat | (&vcnt_b);
                    if (vs) begin
                        vs_lines_d = cnt_inc(vsl_b);
                        sat        = sat | (&vsl_b);
                    end
                end

                crc_d = crc_next;
                aud_d = aud_b;
                if (aud_s_q[1]) begin
                    aud_d = aud_inc(aud_b);
                    sat   = sat | (&aud_b);
                end

                if (sat) err_d[ERR_SAT] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            s_valid_q    <= 1'b0;
            uo_q         <= '0;
            aud_s_q      <= '0;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            hcnt_q       <= '0;
            hs_cnt_q     <= '0;
            vcnt_q       <= '0;
            vs_lines_q   <= '0;
            crc_q        <= CRC_INIT;
            aud_q        <= '0;
            rec_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            h_total_q    <= '0;
            h_sync_len_q <= '0;
            v_total_q    <= '0;
            v_sync_len_q <= '0;
            pix_crc_q    <= '0;
            aud_high_q   <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            s_valid_q    <= s_valid_d;
            uo_q         <= uo_d;
            aud_s_q      <= aud_s_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            hcnt_q       <= hcnt_d;
            hs_cnt_q     <= hs_cnt_d;
            vcnt_q       <= vcnt_d;
            vs_lines_q   <= vs_lines_d;
            crc_q        <= crc_d;
            aud_q        <= aud_d;
            rec_valid_q  <= rec_valid_d;
            frame_done_q <= frame_done_d;
            h_total_q    <= h_total_d;
            h_sync_len_q <= h_sync_len_d;
            v_total_q    <= v_total_d;
            v_sync_len_q <= v_sync_len_d;
            pix_crc_q    <= pix_crc_d;
            aud_high_q   <= aud_high_d;
            err_q        <= err_d;
        end
    end

    assign frame_done = frame_done_q;
    assign locked     = (state_q == RUN);
    assign h_total    = h_total_q;
    assign h_sync_len = h_sync_len_q;
    assign v_total    = v_total_q;
    assign v_sync_len = v_sync_len_q;
    assign pix_crc    = pix_crc_q;
    assign aud_high   = aud_high_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vga_pin_monitor.sv
// Scoreboard bench for vga_pin_monitor: frames are generated with known geometry,
// the expected record is queued at the vsync-edge sample and popped on frame_done.
module tb_vga_pin_monitor;

    localparam int CNT_BITS = 11;
    localparam int AUD_BITS = 20;

    logic                clk;
    logic                reset;
    logic                sample_en;
    logic [7:0]          uo_pins;
    logic [7:0]          uio_pins;
    logic                frame_done;
    logic                locked;
    logic [CNT_BITS-1:0] h_total, h_sync_len, v_total, v_sync_len;
    logic [15:0]         pix_crc;
    logic [AUD_BITS-1:0] aud_high;
    logic [3:0]          err;

    vga_pin_monitor #(.CNT_BITS(CNT_BITS), .AUD_BITS(AUD_BITS), .CRC_POLY(16'h1021)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en),
        .uo_pins(uo_pins), .uio_pins(uio_pins),
        .frame_done(frame_done), .locked(locked),
        .h_total(h_total), .h_sync_len(h_sync_len),
        .v_total(v_total), .v_sync_len(v_sync_len),
        .pix_crc(pix_crc), .aud_high(aud_high), .err(err)
    );

    typedef struct {
        logic [CNT_BITS-1:0] ht, hsl, vt, vsl;
        logic [15:0]         crc;
        logic [AUD_BITS-1:0] aud;
        logic [3:0]          err;
        int                  cyc;
    } rec_t;

    rec_t     q[$];
    rec_t     pend;
    bit       pend_valid;
    logic [3:0] exp_err;
    int       last_vt, h_prev, run_len, gap, cyc;
    int       checks, failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] crc6_ref(input logic [15:0] c, input logic [5:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 5; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        rec_t e;
        if (frame_done === 1'b1) begin
            if (q.size() == 0) begin
                check_eq("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check_eq("rec_latency",    cyc,        e.cyc);
                check_eq("rec_h_total",    h_total,    e.ht);
                check_eq("rec_h_sync_len", h_sync_len, e.hsl);
                check_eq("rec_v_total",    v_total,    e.vt);
                check_eq("rec_v_sync_len", v_sync_len, e.vsl);
                check_eq("rec_pix_crc",    pix_crc,    e.crc);
                check_eq("rec_aud_high",   aud_high,   e.aud);
                check_eq("rec_err",        err,        e.err);
            end
        end
    end

    // Stall cycles carry random pins; they must not affect any result.
    task automatic put_sample(input logic [7:0] uo, input logic [7:0] uio, input bit push);
        for (int g = 1; g < gap; g++) begin
            @(negedge clk);
            sample_en = 1'b0;
            uo_pins   = 8'($urandom);
            uio_pins  = 8'($urandom);
        end
        @(negedge clk);
        sample_en = 1'b1;
        uo_pins   = uo;
        uio_pins  = uio;
        if (push) begin
            pend.cyc = cyc + 2;
            q.push_back(pend);
        end
    endtask

    task automatic idle_lines(input int n);
        logic [7:0] uo;
        for (int l = 0; l < n; l++) begin
            for (int x = 0; x < 10; x++) begin
                uo    = 8'($urandom);
                uo[7] = ~(x < 2);
                uo[3] = 1'b1;
                put_sample(uo, {2'b01, 6'($urandom)}, 1'b0);
            end
        end
    endtask

    task automatic drive_frame(input int nlines, input int short_line, input bit ramp,
                               input bit aud_tog, input int bad_idx);
        int         s, len, aud_sum;
        bit         hs_b, vs_b, a, push;
        logic [5:0] d;
        logic [7:0] uo, uio;
        logic [15:0] crc;
        s       = 0;
        aud_sum = 0;
        crc     = 16'hFFFF;
        len     = 10;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? 9 : 10;
            for (int x = 0; x < len; x++) begin
                hs_b = (x < 2);
                vs_b = (l < 2);
                d    = ramp ? 6'(s) : 6'd0;
                a    = aud_tog && (s % 4 == 0);
                uo   = {~hs_b, d[0], d[2], d[4], ~vs_b, d[1], d[3], d[5]};
                uio  = {a, ~a, 6'($urandom)};
                push = 1'b0;
                if (s == bad_idx) begin
                    uio[6]     = a;
                    exp_err[0] = 1'b1;
                end
                if (x == 0) begin
                    if (run_len != 0) begin
                        if (h_prev != 0 && run_len != h_prev) exp_err[3] = 1'b1;
                        h_prev = run_len;
                    end
                    run_len = 0;
                end
                if (s == 0 && pend_valid) begin
                    if (last_vt != 0 && int'(pend.vt) != last_vt) exp_err[2] = 1'b1;
                    last_vt  = int'(pend.vt);
                    pend.err = exp_err;
                    push     = 1'b1;
                end
                crc     = crc6_ref(crc, d);
                aud_sum = aud_sum + int'(a);
                run_len++;
                s++;
                put_sample(uo, uio, push);
            end
        end
        pend.ht    = CNT_BITS'(len);
        pend.hsl   = CNT_BITS'(2);
        pend.vt    = CNT_BITS'(nlines);
        pend.vsl   = CNT_BITS'(2);
        pend.crc   = crc;
        pend.aud   = AUD_BITS'(aud_sum);
        pend_valid = 1'b1;
    endtask

    task automatic check_cleared();
        check_eq("clr_frame_done", frame_done, 1'b0);
        check_eq("clr_locked",     locked,     1'b0);
        check_eq("clr_h_total",    h_total,    '0);
        check_eq("clr_h_sync_len", h_sync_len, '0);
        check_eq("clr_v_total",    v_total,    '0);
        check_eq("clr_v_sync_len", v_sync_len, '0);
        check_eq("clr_pix_crc",    pix_crc,    16'h0000);
        check_eq("clr_aud_high",   aud_high,   '0);
        check_eq("clr_err",        err,        4'h0);
    endtask

    task automatic clear_model();
        pend_valid = 1'b0;
        exp_err    = 4'h0;
        last_vt    = 0;
        h_prev     = 0;
        run_len    = 0;
        gap        = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        sample_en = 1'b0;
        uo_pins   = 8'hFF;
        uio_pins  = 8'h80;
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_cleared();

        idle_lines(2);
        check_eq("hunt_locked", locked, 1'b0);

        // Black frames, audio silent.
        drive_frame(6, -1, 1'b0, 1'b0, -1);
        check_eq("locked_after_vsync", locked, 1'b1);
        drive_frame(6, -1, 1'b0, 1'b0, -1);
        drive_frame(6, -1, 1'b0, 1'b0, -1);

        // Pixel ramp with audio toggling 1 in 4.
        repeat (3) drive_frame(6, -1, 1'b1, 1'b1, -1);

        gap = 3;
        repeat (2) drive_frame(6, -1, 1'b1, 1'b1, -1);
        gap = 1;

        drive_frame(6, -1, 1'b1, 1'b1, 5);
        drive_frame(6, 3, 1'b1, 1'b1, -1);
        drive_frame(7, -1, 1'b1, 1'b1, -1);
        drive_frame(6, -1, 1'b1, 1'b1, -1);
        drive_frame(6, -1, 1'b1, 1'b1, -1);

        // Abort mid-frame with an asynchronous reset.
        drive_frame(3, -1, 1'b1, 1'b1, -1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_cleared();
        @(negedge clk);
        sample_en = 1'b0;
        reset     = 1'b0;
        clear_model();

        idle_lines(2);
        check_eq("relock_hunt", locked, 1'b0);
        drive_frame(6, -1, 1'b1, 1'b1, -1);
        drive_frame(6, -1, 1'b0, 1'b1, -1);

        @(negedge clk);
        sample_en = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
